pc_fetch_gen: RTL
=================

PC_FETCH_GEN -- requirements
Module: pc_fetch_gen

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of all program-counter values.
REQ-002 Parameter STEP, default 4, sequential increment; SHALL be a power of two not exceeding 2^PC_WIDTH.
REQ-003 Parameter NUM_REDIR, default 2, number of redirect channels; channel 0 is highest priority.
REQ-004 Parameter RESET_PC, default 0, PC value loaded by reset; SHALL be STEP-aligned.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 hold  input  1  pipeline stall; freezes PC issue while high.
REQ-008 redir_valid  input  NUM_REDIR  per-channel redirect request (branch, jump, trap).
REQ-009 redir_addr  input  NUM_REDIR*PC_WIDTH  packed targets; channel i occupies bits [i*PC_WIDTH +: PC_WIDTH].
REQ-010 pc_ready  input  1  fetch stage accepts pc_out this cycle.
REQ-011 pc_valid  output  1  pc_out is a valid fetch address.
REQ-012 pc_out  output  PC_WIDTH  current fetch address.
REQ-013 redir_src  output  NUM_REDIR  registered one-hot of the channel applied last cycle; zero otherwise.
REQ-014 misalign  output  1  registered one-cycle pulse: applied redirect target was not STEP-aligned.

Function
REQ-015 States: BOOT, RUN, STALL; BOOT entered only by reset.
REQ-016 BOOT: pc_valid=0, pc_out=RESET_PC; next cycle goes to RUN or STALL (per hold) with pc_out unchanged.
REQ-017 RUN: pc_valid=1; STALL: pc_valid=0 and pc_out frozen.
REQ-018 Transfer occurs when pc_valid && pc_ready; only a transfer advances pc_out by STEP, modulo 2^PC_WIDTH (wrap from max to 0, no flag).
REQ-019 RUN with !pc_ready and no redirect: pc_out and pc_valid held stable.
REQ-020 Redirect selection: lowest-index asserted redir_valid bit wins; others in the same cycle are dropped.
REQ-021 Applied target = selected address with low log2(STEP) bits cleared; misalign pulses if any cleared bit was 1.
REQ-022 Redirect in RUN, not holding: next pc_out = target, regardless of pc_ready; an unaccepted current PC is discarded, an accepted one is not repeated.
REQ-023 hold=1 in RUN or STALL: next state STALL; redirects arriving are stored in a single pending register (valid bit + target), later cycles overwrite earlier; redir_src/misalign report at capture time.
REQ-024 STALL with hold=0: next state RUN; pc_out = same-cycle redirect target if any, else pending target if pending valid, else unchanged; pending cleared.
REQ-025 Redirect in BOOT is captured as pending and applied on the BOOT exit cycle per REQ-024 rules.
REQ-026 Latency: redirect or transfer observed on pc_out exactly one cycle later; no combinational path from any input to any output.

Reset
REQ-027 rst=1 overrides all inputs: state BOOT, pc_out=RESET_PC, pc_valid=0, redir_src=0, misalign=0, pending cleared.
REQ-028 Reset asserted mid-stall or with a pending redirect SHALL discard that redirect.

Verification
REQ-029 Reset, then pc_ready=1 constantly (STEP=4, RESET_PC=0) -> pc_valid 0 one cycle, then pc_out 0,4,8,12 on successive cycles.
REQ-030 pc_ready=0 for 3 cycles at pc_out=0x10 -> pc_out stays 0x10, pc_valid=1; after pc_ready=1, 0x14 next.
REQ-031 redir_valid=2'b11, addr0=0x100, addr1=0x200 -> next pc_out=0x100, redir_src=2'b01.
REQ-032 hold=1, redirect 0x40 then 0x80 on later cycle, hold=0 -> pc_valid=0 during hold, then pc_out=0x80, pc_valid=1.
REQ-033 Redirect to 0x103 -> pc_out=0x100, misalign=1 for exactly one cycle.
REQ-034 PC_WIDTH=8, pc_out=0xFC, transfer -> pc_out=0x00; reset asserted during stall with pending -> pc_out=RESET_PC, pending lost.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: program-counter generator for an instruction fetch stage.
//
// Issues sequential fetch addresses (PC_WIDTH bits wide, advancing by STEP)
// through a valid/ready handshake. Redirect channels (branch, jump, trap)
// can override the sequential PC. Channel 0 has the highest priority. A
// stall input freezes issue. Redirects that arrive during a stall, or while
// leaving reset, are kept in a single pending slot and applied when issue
// resumes. Every output comes straight from a register.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   hold         in   stall: freeze PC issue while high
//   redir_valid  in   [NUM_REDIR]            per-channel redirect request
//   redir_addr   in   [NUM_REDIR*PC_WIDTH]   packed redirect targets
//   pc_ready     in   fetch stage accepts pc_out this cycle
//   pc_valid     out  pc_out is a valid fetch address
//   pc_out       out  [PC_WIDTH]             current fetch address
//   redir_src    out  [NUM_REDIR]  one-hot of the channel taken last cycle
//   misalign     out  one-cycle pulse: taken redirect target was not aligned
module pc_fetch_gen #(
    parameter int                    PC_WIDTH  = 32,
    parameter int                    STEP      = 4,
    parameter int                    NUM_REDIR = 2,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = {PC_WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic [NUM_REDIR-1:0]          redir_valid,
    input  logic [NUM_REDIR*PC_WIDTH-1:0] redir_addr,
    input  logic                          pc_ready,
    output logic                          pc_valid,
    output logic [PC_WIDTH-1:0]           pc_out,
    output logic [NUM_REDIR-1:0]          redir_src,
    output logic                          misalign
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] STEP_W   = PC_WIDTH'(STEP);
    localparam logic [PC_WIDTH-1:0] LOW_MASK = PC_WIDTH'(STEP - 1);

    state_t                 state_r, state_nxt_s;
    logic [PC_WIDTH-1:0]    pc_r, pc_nxt_s;
    logic                   pc_valid_r;
    logic                   pend_valid_r, pend_valid_nxt_s;
    logic [PC_WIDTH-1:0]    pend_addr_r, pend_addr_nxt_s;
    logic [NUM_REDIR-1:0]   redir_src_r, redir_src_nxt_s;
    logic                   misalign_r, misalign_nxt_s;

    logic [NUM_REDIR-1:0]   sel_onehot_s;
    logic                   sel_hit_s;
    logic [PC_WIDTH-1:0]    sel_addr_s;
    logic [PC_WIDTH-1:0]    target_s;
    logic                   target_mis_s;
    logic                   xfer_s;

    // Redirect arbitration: isolate the lowest set request bit and mux its address.
    always_comb begin
        sel_onehot_s = redir_valid & (~redir_valid + NUM_REDIR'(1'b1));
        sel_hit_s    = |redir_valid;
        sel_addr_s   = {PC_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REDIR; i++) begin
            sel_addr_s = sel_addr_s |
                         (redir_addr[i*PC_WIDTH +: PC_WIDTH] & {PC_WIDTH{sel_onehot_s[i]}});
        end
        target_s     = sel_addr_s & ~LOW_MASK;
        target_mis_s = |(sel_addr_s & LOW_MASK);
        xfer_s       = pc_valid_r & pc_ready;
    end

    // Next-state, next-PC and pending-redirect logic.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        pend_valid_nxt_s = pend_valid_r;
        pend_addr_nxt_s  = pend_addr_r;
        redir_src_nxt_s  = {NUM_REDIR{1'b0}};
        misalign_nxt_s   = 1'b0;

        // A redirect is reported in the cycle it is selected, whether it is
        // applied at once or parked in the pending slot.
        if (sel_hit_s) begin
            redir_src_nxt_s = sel_onehot_s;
            misalign_nxt_s  = target_mis_s;
        end else begin
            redir_src_nxt_s = {NUM_REDIR{1'b0}};
        end

        case (state_r)
            RUN: begin
                // An address accepted in this cycle must not be issued again,
                // so it advances even when the stall begins now.
                if (xfer_s) begin
                    pc_nxt_s = pc_r + STEP_W;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (hold) begin
                    state_nxt_s = STALL;
                    if (sel_hit_s) begin
                        pend_valid_nxt_s = 1'b1;
                        pend_addr_nxt_s  = target_s;
                    end else begin
                        pend_valid_nxt_s = pend_valid_r;
                    end
                end else begin
                    state_nxt_s = RUN;
                    if (sel_hit_s) begin
                        pc_nxt_s = target_s;
                    end else begin
                        pend_valid_nxt_s = pend_valid_r;
                    end
                end
            end
            BOOT, STALL: begin
                if (hold) begin
                    state_nxt_s = STALL;
                    if (sel_hit_s) begin
                        pend_valid_nxt_s = 1'b1;
                        pend_addr_nxt_s  = target_s;
                    end else begin
                        pend_valid_nxt_s = pend_valid_r;
                    end
                end else begin
                    // Leaving the stall: a fresh redirect beats the parked one.
                    state_nxt_s      = RUN;
                    pend_valid_nxt_s = 1'b0;
                    if (sel_hit_s) begin
                        pc_nxt_s = target_s;
                    end else if (pend_valid_r) begin
                        pc_nxt_s = pend_addr_r;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end
            end
            default: begin
                state_nxt_s      = BOOT;
                pc_nxt_s         = RESET_PC;
                pend_valid_nxt_s = 1'b0;
                pend_addr_nxt_s  = {PC_WIDTH{1'b0}};
            end
        endcase
    end

    // State, PC, pending slot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= BOOT;
            pc_r         <= RESET_PC;
            pc_valid_r   <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_addr_r  <= {PC_WIDTH{1'b0}};
            redir_src_r  <= {NUM_REDIR{1'b0}};
            misalign_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            pc_valid_r   <= (state_nxt_s == RUN);
            pend_valid_r <= pend_valid_nxt_s;
            pend_addr_r  <= pend_addr_nxt_s;
            redir_src_r  <= redir_src_nxt_s;
            misalign_r   <= misalign_nxt_s;
        end
    end

    assign pc_valid  = pc_valid_r;
    assign pc_out    = pc_r;
    assign redir_src = redir_src_r;
    assign misalign  = misalign_r;

endmodule
